// File: rtl/diff_rx_pkg.sv
// Shared types and helpers for the complementary-pair capture receiver.
package diff_rx_pkg;

  localparam int ERR_CNT_W = 16;

  typedef enum logic [1:0] {
    PAIR_ZERO   = 2'd0,
    PAIR_ONE    = 2'd1,
    PAIR_INV_LO = 2'd2,
    PAIR_INV_HI = 2'd3
  } pair_e;

  // Classify one (p, n) leg pair.
  function automatic pair_e decode_pair(input logic p, input logic n);
    case ({p, n})
      2'b10:   decode_pair = PAIR_ONE;
      2'b01:   decode_pair = PAIR_ZERO;
      2'b00:   decode_pair = PAIR_INV_LO;
      default: decode_pair = PAIR_INV_HI;
    endcase
  endfunction

  // Data bit of a pair; invalid pairs follow the p leg.
  function automatic logic pair_bit(input pair_e e);
    return (e == PAIR_ONE) || (e == PAIR_INV_HI);
  endfunction

  function automatic logic pair_invalid(input pair_e e);
    return (e == PAIR_INV_LO) || (e == PAIR_INV_HI);
  endfunction

endpackage

// File: rtl/diff_rx_fifo.sv
// Synchronous capture FIFO. Occupancy is the difference of free-running
// write/read counters carrying one extra MSB. When empty, rdata keeps showing
// the last word that was popped so the stream output never glitches.
module diff_rx_fifo
  import diff_rx_pkg::*;
#(
  parameter int WIDTH = 5,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_cnt;
  logic [AW:0]      r_rd_cnt;
  logic [WIDTH-1:0] r_last;
  logic [AW:0]      w_level;
  logic             w_do_push;
  logic             w_do_pop;
  logic [WIDTH-1:0] w_head;

  assign w_level   = r_wr_cnt - r_rd_cnt;
  assign empty     = (w_level == '0);
  assign full      = (w_level == (AW+1)'(DEPTH));
  assign w_do_pop  = pop & ~empty;
  // A full FIFO still accepts a word when a slot frees up in the same cycle.
  assign w_do_push = push & (~full | w_do_pop);
  assign w_head    = r_mem[r_rd_cnt[AW-1:0]];
  assign rdata     = empty ? r_last : w_head;
  assign level     = w_level;

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_cnt[AW-1:0]] <= wdata;
    end
  end

  // Pointer advance and last-popped word retention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_cnt <= '0;
      r_rd_cnt <= '0;
      r_last   <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_cnt <= r_wr_cnt + (AW+1)'(1);
      end
      if (w_do_pop) begin
        r_rd_cnt <= r_rd_cnt + (AW+1)'(1);
        r_last   <= w_head;
      end
    end
  end

endmodule

// File: rtl/diff_capture_rx.sv
// Receiver for complementary-pair outputs: synchronizes the legs and the
// sample strobe, decodes each pair, tracks word stability, and queues one word
// per strobe rising edge into a FIFO drained over a valid/ready stream.
module diff_capture_rx
  import diff_rx_pkg::*;
#(
  parameter int N_PAIRS       = 5,
  parameter int FIFO_DEPTH    = 16,
  parameter int STABLE_CYCLES = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         enable,
  input  logic                         clear_err,
  input  logic [N_PAIRS-1:0]           in_p,
  input  logic [N_PAIRS-1:0]           in_n,
  input  logic                         strobe,
  output logic [N_PAIRS-1:0]           m_data,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
  output logic [N_PAIRS-1:0]           err_pair,
  output logic                         err_unstable,
  output logic                         overflow,
  output logic [ERR_CNT_W-1:0]         err_count
);

  localparam int STAB_W = (STABLE_CYCLES < 1) ? 1 : $clog2(STABLE_CYCLES + 1);
  localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE_CYCLES);

  logic [N_PAIRS-1:0]   r_p_s1, r_p_s2, r_n_s1, r_n_s2;
  logic                 r_stb_s1, r_stb_s2, r_stb_d;
  logic [1:0]           r_fill;
  logic [N_PAIRS-1:0]   r_word_d;
  logic [STAB_W-1:0]    r_stab_cnt;
  logic [N_PAIRS-1:0]   r_err_pair;
  logic                 r_err_unstable;
  logic                 r_overflow;
  logic [ERR_CNT_W-1:0] r_err_count;

  logic [N_PAIRS-1:0]   w_word;
  logic [N_PAIRS-1:0]   w_inv;
  logic [STAB_W-1:0]    w_stab;
  logic                 w_cap;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_pop;
  logic                 w_drop;

  // Two-flop synchronizers; r_stb_d is the previous synced strobe. r_fill
  // counts edges since reset so the first edge compare uses real samples only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p_s1   <= '0;
      r_p_s2   <= '0;
      r_n_s1   <= '0;
      r_n_s2   <= '0;
      r_stb_s1 <= 1'b0;
      r_stb_s2 <= 1'b0;
      r_stb_d  <= 1'b0;
      r_fill   <= '0;
    end else begin
      r_p_s1   <= in_p;
      r_p_s2   <= r_p_s1;
      r_n_s1   <= in_n;
      r_n_s2   <= r_n_s1;
      r_stb_s1 <= strobe;
      r_stb_s2 <= r_stb_s1;
      r_stb_d  <= r_stb_s2;
      if (r_fill != 2'd3) begin
        r_fill <= r_fill + 2'd1;
      end
    end
  end

  // Per-pair decode of the synced legs into data bits and an invalid mask.
  always_comb begin
    w_word = '0;
    w_inv  = '0;
    for (int i = 0; i < N_PAIRS; i++) begin
      w_word[i] = pair_bit(decode_pair(r_p_s2[i], r_n_s2[i]));
      w_inv[i]  = pair_invalid(decode_pair(r_p_s2[i], r_n_s2[i]));
    end
  end

  // Stability seen by this cycle: 0 in the cycle the word changes.
  assign w_stab = (w_word != r_word_d) ? '0 : r_stab_cnt;
  assign w_cap  = r_stb_s2 & ~r_stb_d & enable & (r_fill == 2'd3);
  assign w_pop  = m_ready & ~w_empty;
  assign w_drop = w_cap & w_full & ~w_pop;

  // Track how many cycles the decoded word has been unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word_d   <= '0;
      r_stab_cnt <= '0;
    end else begin
      r_word_d   <= w_word;
      r_stab_cnt <= (w_stab == STAB_MAX) ? STAB_MAX : w_stab + STAB_W'(1);
    end
  end

  // Sticky error flags and saturating error counter; a clear beats a capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_pair     <= '0;
      r_err_unstable <= 1'b0;
      r_overflow     <= 1'b0;
      r_err_count    <= '0;
    end else if (clear_err) begin
      r_err_pair     <= '0;
      r_err_unstable <= 1'b0;
      r_overflow     <= 1'b0;
      r_err_count    <= '0;
    end else if (w_cap) begin
      r_err_pair <= r_err_pair | w_inv;
      if ((|w_inv) && (r_err_count != '1)) begin
        r_err_count <= r_err_count + ERR_CNT_W'(1);
      end
      if (w_stab < STAB_MAX) begin
        r_err_unstable <= 1'b1;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  diff_rx_fifo #(
    .WIDTH (N_PAIRS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_cap),
    .wdata (w_word),
    .pop   (m_ready),
    .rdata (m_data),
    .full  (w_full),
    .empty (w_empty),
    .level (fifo_level)
  );

  assign m_valid      = ~w_empty;
  assign err_pair     = r_err_pair;
  assign err_unstable = r_err_unstable;
  assign overflow     = r_overflow;
  assign err_count    = r_err_count;

endmodule

// File: tb/tb_diff_capture_rx.sv
// Scoreboard bench for diff_capture_rx: captures are recorded when the strobe
// is driven, a queue model of the FIFO and flags advances on each clock, and a
// monitor compares the DUT against that model on every falling edge.
module tb_diff_capture_rx;

  localparam int N     = 5;
  localparam int DEPTH = 4;
  localparam int STAB  = 2;

  logic                   clk = 1'b0;
  logic                   rst_n, enable, clear_err, strobe, m_ready;
  logic [N-1:0]           in_p, in_n;
  logic [N-1:0]           m_data, err_pair;
  logic                   m_valid, err_unstable, overflow;
  logic [$clog2(DEPTH):0] fifo_level;
  logic [15:0]            err_count;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int last_chg = -100;
  bit mon_on   = 0;
  bit rnd_on   = 0;

  typedef struct {
    logic [N-1:0] word;
    logic [N-1:0] inv;
    bit           unst;
    int           due;
  } cap_t;

  cap_t         pend[$];
  logic [N-1:0] sb[$];
  logic [N-1:0] m_last = '0;
  logic [N-1:0] e_pair = '0;
  bit           e_unst = 0;
  bit           e_ovf  = 0;
  int           e_cnt  = 0;

  diff_capture_rx #(
    .N_PAIRS       (N),
    .FIFO_DEPTH    (DEPTH),
    .STABLE_CYCLES (STAB)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .clear_err    (clear_err),
    .in_p         (in_p),
    .in_n         (in_n),
    .strobe       (strobe),
    .m_data       (m_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .fifo_level   (fifo_level),
    .err_pair     (err_pair),
    .err_unstable (err_unstable),
    .overflow     (overflow),
    .err_count    (err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, want, $time);
    end
  endtask

  // Reference model: queue FIFO plus flags, advanced once per clock.
  bit   mp_full, mp_pop, mp_push;
  cap_t mp_rec;
  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
    if (rst_n === 1'b1) begin
      mp_full = (sb.size() == DEPTH);
      mp_pop  = (sb.size() != 0) && (m_ready === 1'b1);
      mp_push = (pend.size() != 0) && (pend[0].due == cyc);
      if (mp_pop) m_last = sb.pop_front();
      if (mp_push) begin
        mp_rec = pend.pop_front();
        if (!(mp_full && !mp_pop)) sb.push_back(mp_rec.word);
      end
      if (clear_err === 1'b1) begin
        e_pair = '0; e_unst = 0; e_ovf = 0; e_cnt = 0;
      end else if (mp_push) begin
        e_pair = e_pair | mp_rec.inv;
        if (mp_rec.inv != '0 && e_cnt < 65535) e_cnt++;
        if (mp_rec.unst) e_unst = 1;
        if (mp_full && !mp_pop) e_ovf = 1;
      end
    end
  end

  initial forever begin
    @(negedge rst_n);
    sb.delete(); pend.delete();
    m_last = '0; e_pair = '0; e_unst = 0; e_ovf = 0; e_cnt = 0;
  end

  // Monitor: compare DUT outputs with the model away from the active edge.
  initial forever begin
    @(negedge clk);
    if (mon_on && rst_n === 1'b1) begin
      chk("m_valid", m_valid, sb.size() != 0);
      chk("fifo_level", fifo_level, sb.size());
      if (sb.size() != 0) chk("m_data", m_data, sb[0]);
      else                chk("m_data_hold", m_data, m_last);
      chk("err_pair", err_pair, e_pair);
      chk("err_count", err_count, e_cnt);
      chk("err_unstable", err_unstable, e_unst);
      chk("overflow", overflow, e_ovf);
    end
  end

  // Background consumer/clear activity for the random phase.
  initial forever begin
    @(negedge clk);
    if (rnd_on) begin
      m_ready   = ($urandom_range(0, 3) != 0);
      clear_err = ($urandom_range(0, 49) == 0);
    end
  end

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_word(input logic [N-1:0] w, input logic [N-1:0] inv);
    if (w !== in_p) last_chg = cyc;
    in_p = w;
    in_n = ~w ^ inv;
  endtask

  task automatic record(input logic [N-1:0] w, input logic [N-1:0] inv);
    cap_t rec;
    rec.word = w;
    rec.inv  = inv;
    rec.unst = ((cyc - last_chg) < STAB);
    rec.due  = cyc + 3;
    pend.push_back(rec);
  endtask

  task automatic do_capture(input logic [N-1:0] w, input logic [N-1:0] inv,
                            input int gap, input bit en);
    set_word(w, inv);
    wait_neg(gap);
    enable = en;
    strobe = 1'b1;
    if (en) record(w, inv);
    wait_neg(2);
    strobe = 1'b0;
    wait_neg(2);
    enable = 1'b1;
  endtask

  task automatic pulse_clear();
    clear_err = 1'b1;
    wait_neg(1);
    clear_err = 1'b0;
  endtask

  task automatic drain(input int limit);
    m_ready = 1'b1;
    wait_neg(4);
    for (int i = 0; i < limit && sb.size() != 0; i++) @(negedge clk);
    chk("drain_level", fifo_level, 0);
    chk("drain_valid", m_valid, 0);
  endtask

  logic [N-1:0] rw, rinv;
  int           rgap;
  bit           ren;

  initial begin
    rst_n = 1'b0; enable = 1'b1; clear_err = 1'b0; strobe = 1'b0; m_ready = 1'b0;
    in_p = '0; in_n = '1;
    wait_neg(3);
    rst_n  = 1'b1;
    mon_on = 1;
    wait_neg(1);
    chk("rst_level", fifo_level, 0);
    chk("rst_valid", m_valid, 0);
    chk("rst_data", m_data, 0);
    chk("rst_errcnt", err_count, 0);

    // Basic capture and latency
    m_ready = 1'b1;
    set_word(5'b10110, 5'b0);
    wait_neg(10);
    strobe = 1'b1;
    record(5'b10110, 5'b0);
    wait_neg(2);
    chk("t1_valid_early", m_valid, 0);
    wait_neg(1);
    chk("t1_valid_at", m_valid, 1);
    chk("t1_data", m_data, 5'b10110);
    strobe = 1'b0;
    wait_neg(2);
    chk("t1_err_pair", err_pair, 0);
    chk("t1_unstable", err_unstable, 0);

    // Invalid pair
    m_ready = 1'b0;
    do_capture(5'b00100, 5'b00100, 5, 1'b1);
    wait_neg(1);
    chk("t2_err_pair", err_pair, 5'b00100);
    chk("t2_err_count", err_count, 1);
    chk("t2_bit2", m_data[2], 1);
    pulse_clear();
    chk("t2_clr_pair", err_pair, 0);
    chk("t2_clr_count", err_count, 0);
    chk("t2_clr_level", fifo_level, 1);
    drain(20);

    // Overflow
    m_ready = 1'b0;
    for (int w = 1; w <= 5; w++) do_capture(5'(w), 5'b0, 3, 1'b1);
    wait_neg(1);
    chk("t3_level", fifo_level, 4);
    chk("t3_overflow", overflow, 1);
    drain(20);
    pulse_clear();

    // Full plus pop in the capture cycle
    m_ready = 1'b0;
    for (int w = 1; w <= 4; w++) do_capture(5'(w), 5'b0, 3, 1'b1);
    set_word(5'd9, 5'b0);
    wait_neg(3);
    strobe = 1'b1;
    record(5'd9, 5'b0);
    wait_neg(2);
    m_ready = 1'b1;
    strobe  = 1'b0;
    wait_neg(1);
    m_ready = 1'b0;
    chk("t4_level", fifo_level, 4);
    chk("t4_overflow", overflow, 0);
    chk("t4_head", m_data, 2);
    wait_neg(2);
    drain(20);

    // Unstable word
    m_ready = 1'b0;
    set_word(5'h0A, 5'b0);
    wait_neg(5);
    do_capture(5'h15, 5'b0, 1, 1'b1);
    chk("t5_unstable", err_unstable, 1);
    chk("t5_level", fifo_level, 1);
    chk("t5_data", m_data, 5'h15);
    pulse_clear();
    drain(20);

    // Reset mid-stream, held strobe, enable gating
    m_ready = 1'b0;
    do_capture(5'h03, 5'b0, 3, 1'b1);
    do_capture(5'h06, 5'b0, 3, 1'b1);
    do_capture(5'h0C, 5'b00001, 3, 1'b1);
    wait_neg(1);
    chk("t6_level_pre", fifo_level, 3);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("t6_rst_level", fifo_level, 0);
    chk("t6_rst_valid", m_valid, 0);
    chk("t6_rst_data", m_data, 0);
    chk("t6_rst_pair", err_pair, 0);
    chk("t6_rst_unst", err_unstable, 0);
    chk("t6_rst_ovf", overflow, 0);
    chk("t6_rst_cnt", err_count, 0);
    strobe = 1'b1;
    wait_neg(2);
    rst_n = 1'b1;
    last_chg = cyc;
    wait_neg(8);
    chk("t6_held_level", fifo_level, 0);
    chk("t6_held_valid", m_valid, 0);
    strobe = 1'b0;
    wait_neg(3);
    do_capture(5'h11, 5'b0, 2, 1'b1);
    chk("t6_fresh_level", fifo_level, 1);
    do_capture(5'h07, 5'b0, 3, 1'b0);
    chk("t6_dis_level", fifo_level, 1);
    drain(20);

    // Randomized traffic
    rnd_on = 1;
    repeat (40) begin
      rw   = 5'($urandom);
      rinv = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'b0;
      rgap = $urandom_range(0, 4);
      ren  = ($urandom_range(0, 5) != 0);
      do_capture(rw, rinv, rgap, ren);
    end
    rnd_on = 0;
    wait_neg(1);
    m_ready   = 1'b1;
    clear_err = 1'b0;
    drain(50);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
